pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipelined CPU.
//  - Drives the write enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  - Resolves load-use hazards, ID-stage branch flushes and multi-cycle data-memory waits (with timeout).
//  - Sits beside the datapath; holds no datapath values itself.
// PARAMETERS
//  WAIT_MAX  16  max consecutive MEM_WAIT cycles before the timeout fires (>=1)
//  CNT_W     32  width of the perf counters (optional feature only)
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  MemRead_ex     in   1      load instruction in EX
//  Rd_ex          in   5      EX destination register
//  Rn_id          in   5      ID source register 1
//  Rm_id          in   5      ID source register 2
//  uses_Rm_id     in   1      ID instruction reads Rm
//  BrTaken_id     in   1      branch resolved taken in ID
//  dm_req_mem     in   1      MEM stage accessing data memory (load or store)
//  dm_ready       in   1      data memory completes access this cycle
//  pc_en          out  1      PC write enable
//  if_id_en       out  1      IF/ID enable
//  if_id_flush    out  1      IF/ID loads NOP
//  id_ex_en       out  1      ID/EX enable
//  id_ex_bubble   out  1      ID/EX loads zero control (RegWrite=MemWrite=0)
//  ex_mem_en      out  1      EX/MEM enable
//  mem_wb_bubble  out  1      MEM/WB loads RegWrite=0
//  dm_timeout     out  1      sticky: memory wait exceeded WAIT_MAX
//  stall_cycles   out  CNT_W  freeze and load-use stall cycles
//  flush_count    out  CNT_W  IF/ID flushes
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT. The reset state is RUN with wait_cnt=0 and dm_timeout=0.
//  - Output defaults: all enables 1, all bubble/flush 0. These are also the outputs while reset is held.
//  - Outputs are combinational from the state and the current inputs (0-cycle latency).
//  - RUN, memory miss: dm_req_mem=1 and dm_ready=0.
//    - Freeze: pc_en, if_id_en, id_ex_en and ex_mem_en all 0; mem_wb_bubble=1.
//    - Next state MEM_WAIT; wait_cnt<=1.
//  - RUN, memory hit: dm_req_mem=1 and dm_ready=1 is a zero-wait access with no freeze.
//  - MEM_WAIT: same freeze outputs as a miss.
//    - dm_ready=1: release in the same cycle (defaults apply, mem_wb_bubble=0); next state RUN; wait_cnt<=0.
//    - wait_cnt==WAIT_MAX with no ready: set dm_timeout, release as if ready, go to RUN.
//    - Otherwise wait_cnt increments.
//  - Load-use (RUN, no freeze): MemRead_ex && Rd_ex!=31 && (Rd_ex==Rn_id || (uses_Rm_id && Rd_ex==Rm_id)).
//    - Drives pc_en=0, if_id_en=0, id_ex_bubble=1 for exactly that cycle.
//    - X31 (XZR) never hazards.
//  - Branch: BrTaken_id with no stall and no freeze -> if_id_flush=1 for one cycle.
//  - Priority: memory freeze > load-use stall > branch flush.
//    - A suppressed flush is not lost: ID holds, so BrTaken_id re-presents on a later cycle.
//  - dm_timeout clears only on reset.
//  - Reset mid-wait forces RUN next cycle and clears wait_cnt and counters.
//  - dm_req_mem=1 with dm_ready=1 on the first cycle never enters MEM_WAIT.
// CONFIGURATION
//  - Macro PIPE_PERF_CNT_EN, when defined:
//    - stall_cycles +1 on every cycle with pc_en=0.
//    - flush_count +1 on every if_id_flush.
//    - Both saturate at all-ones and clear on reset.
//  - Undefined: both ports are tied to 0 and no counter flops exist; the port list is unchanged.
// STRUCTURE
//  - Package pipe_ctrl_pkg:
//    - typedef enum logic {RUN, MEM_WAIT} hz_state_t
//    - localparam XZR = 5'd31
//    - REG_W = 5
//  - Sub-module sat_counter #(W): clk, reset, inc, count; instantiated twice inside the PIPE_PERF_CNT_EN block.
// TESTING
//  1. Load X3 in EX, ID reads Rn=3 -> one cycle pc_en=0, if_id_en=0, id_ex_bubble=1; then defaults.
//  2. Load Rd_ex=31, ID reads Rn=31 -> no stall.
//  3. dm_req_mem with ready after 3 cycles:
//     - 3 freeze cycles with mem_wb_bubble=1, release on the ready cycle.
//     - stall_cycles=3 (EN build).
//  4. dm_req_mem with ready never, WAIT_MAX=4 -> release after 4 MEM_WAIT cycles; dm_timeout=1 and stays 1 until reset.
//  5. BrTaken_id together with a load-use hazard:
//     - Cycle 1: stall only, no flush.
//     - Cycle 2: if_id_flush=1; flush_count=1.
//  6. Reset asserted during MEM_WAIT -> next cycle RUN, all enables 1, counters 0, dm_timeout 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types, constants and hazard helper for the pipeline hazard controller
package pipe_ctrl_pkg;
   typedef enum logic {RUN, MEM_WAIT} hz_state_t;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] XZR = 5'd31;
   // Load in EX whose destination feeds an ID source; XZR is hardwired zero and never hazards
   function automatic logic load_use(input logic mem_read, input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rn, input logic [REG_W-1:0] rm,
                                     input logic uses_rm);
      return mem_read && (rd != XZR) && ((rd == rn) || (uses_rm && (rd == rm)));
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones, cleared by synchronous reset
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   logic [W-1:0] r_count;
   // Count events until saturated
   always_ff @(posedge clk) begin
      if (reset) r_count <= '0;
      else if (inc && (r_count != '1)) r_count <= r_count + 1'b1;
   end
   assign count = r_count;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline; perf counters under PIPE_PERF_CNT_EN
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemRead_ex,
   input  logic [REG_W-1:0] Rd_ex,
   input  logic [REG_W-1:0] Rn_id,
   input  logic [REG_W-1:0] Rm_id,
   input  logic             uses_Rm_id,
   input  logic             BrTaken_id,
   input  logic             dm_req_mem,
   input  logic             dm_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_bubble,
   output logic             ex_mem_en,
   output logic             mem_wb_bubble,
   output logic             dm_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);
   localparam int WC_W = $clog2(WAIT_MAX + 1);

   hz_state_t       r_state, w_state_nxt;
   logic [WC_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic            r_timeout, w_timeout_nxt;
   logic            w_freeze, w_stall, w_flush;

   // State, wait counter and sticky timeout registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   // Next state and stall causes; freeze beats load-use, load-use beats branch flush
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_timeout_nxt  = r_timeout;
      w_freeze       = 1'b0;
      w_stall        = 1'b0;
      w_flush        = 1'b0;
      if (!reset) begin
         if (r_state == RUN) begin
            if (dm_req_mem && !dm_ready) begin
               w_freeze       = 1'b1;
               w_state_nxt    = MEM_WAIT;
               w_wait_cnt_nxt = WC_W'(1);
            end else begin
               w_stall = load_use(MemRead_ex, Rd_ex, Rn_id, Rm_id, uses_Rm_id);
               w_flush = BrTaken_id && !w_stall;
            end
         end else if (dm_ready) begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
         end else if (r_wait_cnt == WC_W'(WAIT_MAX)) begin
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
            w_timeout_nxt  = 1'b1;
         end else begin
            w_freeze       = 1'b1;
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
         end
      end
   end

   assign pc_en         = !(w_freeze || w_stall);
   assign if_id_en      = !(w_freeze || w_stall);
   assign if_id_flush   = w_flush;
   assign id_ex_en      = !w_freeze;
   assign id_ex_bubble  = w_stall;
   assign ex_mem_en     = !w_freeze;
   assign mem_wb_bubble = w_freeze;
   assign dm_timeout    = r_timeout;

`ifdef PIPE_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (!pc_en),
      .count(stall_cycles)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (if_id_flush),
      .count(flush_count)
   );
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random stimulus checked against a cycle-level behavioural model
module tb_pipe_hazard_ctrl;
   localparam int WM   = 4;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, MemRead_ex, uses_Rm_id, BrTaken_id, dm_req_mem, dm_ready;
   logic [4:0]    Rd_ex, Rn_id, Rm_id;
   logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble;
   logic          dm_timeout;
   logic [CW-1:0] stall_cycles, flush_count;

   int n_chk = 0;
   int n_err = 0;
   bit m_wait, m_to;
   int m_cnt, m_sc, m_fc;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .MemRead_ex   (MemRead_ex),
      .Rd_ex        (Rd_ex),
      .Rn_id        (Rn_id),
      .Rm_id        (Rm_id),
      .uses_Rm_id   (uses_Rm_id),
      .BrTaken_id   (BrTaken_id),
      .dm_req_mem   (dm_req_mem),
      .dm_ready     (dm_ready),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .if_id_flush  (if_id_flush),
      .id_ex_en     (id_ex_en),
      .id_ex_bubble (id_ex_bubble),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_bubble(mem_wb_bubble),
      .dm_timeout   (dm_timeout),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, predict and compare mid-cycle, then advance the model at the edge
   task automatic step(input logic r, input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic um, input logic br, input logic req,
                       input logic rdy);
      bit frz, stl, fls, nw, nto;
      int nc;
      reset = r; MemRead_ex = mr; Rd_ex = rd; Rn_id = rn; Rm_id = rm;
      uses_Rm_id = um; BrTaken_id = br; dm_req_mem = req; dm_ready = rdy;
      #4;
      frz = 0; stl = 0; fls = 0; nw = m_wait; nc = m_cnt; nto = m_to;
      if (!r) begin
         if (!m_wait) begin
            if (req && !rdy) begin frz = 1; nw = 1; nc = 1; end
            else if (mr && rd != 5'd31 && (rd == rn || (um && rd == rm))) stl = 1;
            else fls = br;
         end else if (rdy) nw = 0;
         else if (m_cnt == WM) begin nw = 0; nto = 1; end
         else begin frz = 1; nc = m_cnt + 1; end
      end
      chk("ctl", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble},
          {!(frz || stl), !(frz || stl), fls, !frz, stl, !frz, frz});
      chk("timeout", dm_timeout, m_to);
      chk("stall_cycles", stall_cycles, PERF ? m_sc : 0);
      chk("flush_count", flush_count, PERF ? m_fc : 0);
      @(posedge clk);
      if (r) begin
         m_wait = 0; m_cnt = 0; m_to = 0; m_sc = 0; m_fc = 0;
      end else begin
         m_wait = nw; m_cnt = nc; m_to = nto;
         if ((frz || stl) && m_sc < CMAX) m_sc++;
         if (fls && m_fc < CMAX) m_fc++;
      end
      #1;
   endtask

   task automatic rst_step();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [4:0] pick();
      int k = $urandom_range(0, 3);
      return (k == 3) ? 5'd31 : 5'(k);
   endfunction

   initial begin
      reset = 1; MemRead_ex = 0; Rd_ex = 0; Rn_id = 0; Rm_id = 0;
      uses_Rm_id = 0; BrTaken_id = 0; dm_req_mem = 0; dm_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      m_wait = 0; m_cnt = 0; m_to = 0; m_sc = 0; m_fc = 0;
      rst_step();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 3, 0, 0, 0, 0, 0);
      step(0, 0, 3, 3, 0, 0, 0, 0, 0);
      step(0, 1, 31, 31, 31, 1, 0, 0, 0);
      step(0, 1, 4, 0, 4, 1, 0, 0, 0);
      step(0, 1, 4, 0, 4, 0, 0, 0, 0);
      rst_step();
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("t3_stall_cycles", stall_cycles, PERF ? 3 : 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      rst_step();
      repeat (5) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("t4_timeout_set", dm_timeout, 1);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t4_timeout_sticky", dm_timeout, 1);
      rst_step();
      chk("t4_timeout_clear", dm_timeout, 0);
      step(0, 1, 2, 2, 0, 0, 1, 0, 0);
      step(0, 0, 2, 2, 0, 0, 1, 0, 0);
      chk("t5_flush_count", flush_count, PERF ? 1 : 0);
      rst_step();
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_stall_cycles", stall_cycles, 0);
      rst_step();
      repeat (CMAX + 20) step(0, 1, 5, 5, 0, 0, 0, 0, 0);
      chk("sat_stall_cycles", stall_cycles, PERF ? CMAX : 0);
      rst_step();
      repeat (2000)
         step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), pick(), pick(), pick(),
              1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0));
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
